// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the req/gnt/rvalid bus.
// Serves word reads and byte-enabled writes from an internal RAM with
// configurable grant and response latency, one transaction outstanding.
// Optional feature: define MEM_RESPONDER_RANGE_CHECK_EN to flag addresses
// above the RAM (write suppressed, error response, read data zero).
// Without it, upper address bits alias and mem_error_o stays 0.
module mem_responder #(
  parameter int WORD_COUNT     = 1024,
  parameter int GNT_LATENCY    = 0,
  parameter int RVALID_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_error_o
);

  localparam int AW = $clog2(WORD_COUNT);
  localparam logic [3:0] GNT_LOAD = (GNT_LATENCY > 0) ? 4'(GNT_LATENCY - 1) : 4'd0;
  localparam logic [3:0] RSP_LOAD = 4'(RVALID_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT_WAIT,
    S_RESPOND
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_ctr;
  logic [3:0]    w_ctr_nxt;
  logic          w_gnt;
  logic          w_rvalid_nxt;
  logic          w_oor;
  logic          w_unused;
  logic [AW-1:0] w_word;
  logic [31:0]   w_rd_word;

  logic [31:0]   r_mem [WORD_COUNT];
  logic          r_resp_we;
  logic          r_resp_err;
  logic [31:0]   r_resp_data;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic          r_error;

  // Response fields for the beat being launched: straight from the request
  // when the response follows the grant immediately, else from the capture.
  logic          w_cur_we;
  logic          w_cur_err;
  logic [31:0]   w_cur_data;

  assign w_word    = mem_addr_i[AW+1:2];
  assign w_rd_word = r_mem[w_word];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign w_oor    = |mem_addr_i[31:AW+2];
  assign w_unused = ^mem_addr_i[1:0];
`else
  assign w_oor    = 1'b0;
  assign w_unused = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};
`endif

  // Next-state, counter and grant decode for the request/response FSM.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    w_gnt       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          if (GNT_LATENCY == 0) begin
            w_gnt       = 1'b1;
            w_state_nxt = S_RESPOND;
            w_ctr_nxt   = RSP_LOAD;
          end else begin
            w_state_nxt = S_GRANT_WAIT;
            w_ctr_nxt   = GNT_LOAD;
          end
        end
      end
      S_GRANT_WAIT: begin
        if (!mem_req_i) begin
          w_state_nxt = S_IDLE;
          w_ctr_nxt   = 4'd0;
        end else if (r_ctr != 4'd0) begin
          w_ctr_nxt = r_ctr - 4'd1;
        end else begin
          w_gnt       = 1'b1;
          w_state_nxt = S_RESPOND;
          w_ctr_nxt   = RSP_LOAD;
        end
      end
      S_RESPOND: begin
        // rvalid is high during the last Respond cycle (ctr=0); leave afterwards.
        if (r_ctr != 4'd0) w_ctr_nxt = r_ctr - 4'd1;
        else               w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (reset) w_gnt = 1'b0;
  end

  // The rvalid pulse lands RVALID_LATENCY cycles after the grant cycle.
  assign w_rvalid_nxt = (w_gnt && (RVALID_LATENCY == 1)) ||
                        ((r_state == S_RESPOND) && (r_ctr == 4'd1));

  assign w_cur_we   = w_gnt ? mem_we_i : r_resp_we;
  assign w_cur_err  = w_gnt ? w_oor    : r_resp_err;
  assign w_cur_data = w_gnt ? (w_oor ? 32'h0 : w_rd_word) : r_resp_data;

  // State, counter, request capture and response registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      r_state     <= S_IDLE;
      r_ctr       <= 4'd0;
      r_resp_we   <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_data <= 32'h0;
      r_rvalid    <= 1'b0;
      r_rdata     <= 32'h0;
      r_error     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctr    <= w_ctr_nxt;
      r_rvalid <= w_rvalid_nxt;
      if (w_gnt) begin
        r_resp_we   <= mem_we_i;
        r_resp_err  <= w_oor;
        r_resp_data <= w_oor ? 32'h0 : w_rd_word;
      end
      if (w_rvalid_nxt) begin
        r_error <= w_cur_err;
        if (!w_cur_we) r_rdata <= w_cur_data;
      end
    end
  end

  // Byte-enabled RAM write at the grant edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; contents survive reset and start undefined.
    if (w_gnt && mem_we_i && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_i[b]) r_mem[w_word][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end
  end

  assign mem_gnt_o    = w_gnt;
  assign mem_rvalid_o = r_rvalid;
  assign mem_rdata_o  = r_rdata;
  assign mem_error_o  = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder.
// Instance 0 uses default latencies, instance 1 uses GNT_LATENCY=3 and
// RVALID_LATENCY=4. Stimulus pushes expected responses; a negedge monitor
// pops and compares whenever rvalid is seen.
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          gcyc;
  } exp_t;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst    [2];
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last   [2];
  int          rv_cnt [2];
  int          push_cnt [2];
  int          lat    [2];
  int          cyc;
  int          n_checks;
  int          n_errors;

  mem_responder #(.WORD_COUNT(1024)) u_dut_a (
    .clk(clk), .reset(rst[0]), .mem_req_i(req[0]), .mem_addr_i(addr[0]),
    .mem_we_i(we[0]), .mem_be_i(be[0]), .mem_wdata_i(wdata[0]),
    .mem_gnt_o(gnt[0]), .mem_rvalid_o(rvalid[0]), .mem_rdata_o(rdata[0]),
    .mem_error_o(err[0])
  );

  mem_responder #(.WORD_COUNT(1024), .GNT_LATENCY(3), .RVALID_LATENCY(4)) u_dut_b (
    .clk(clk), .reset(rst[1]), .mem_req_i(req[1]), .mem_addr_i(addr[1]),
    .mem_we_i(we[1]), .mem_be_i(be[1]), .mem_wdata_i(wdata[1]),
    .mem_gnt_o(gnt[1]), .mem_rvalid_o(rvalid[1]), .mem_rdata_o(rdata[1]),
    .mem_error_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every response beat against the head of the queue.
  task automatic mon(input int s);
    exp_t e;
    bit   empty;
    if (rvalid[s] === 1'b1) begin
      rv_cnt[s]++;
      empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rvalid dut%0d: got rvalid=1, required no response pending (cycle %0d)", s, cyc);
      end else begin
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("rdata dut%0d", s), rdata[s], e.data);
        check($sformatf("error dut%0d", s), {31'b0, err[s]}, {31'b0, e.err});
        check($sformatf("rvalid_latency dut%0d", s), 32'(cyc - e.gcyc), 32'(lat[s]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Drive one request, wait (bounded) for its grant, optionally log the
  // expected response, and optionally keep req high after the grant edge.
  task automatic issue(input int s, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit hold, input bit push,
                       output int waits, output int gcyc);
    exp_t e;
    bit   done;
    waits = 0;
    gcyc  = -1;
    done  = 1'b0;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; be[s] = b; wdata[s] = d;
    while (!done) begin
      #1;
      if (gnt[s] === 1'b1) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          n_checks++;
          n_errors++;
          $display("FAIL gnt_timeout dut%0d: got no grant in 20 cycles, required a grant", s);
          req[s] = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    gcyc = cyc;
    if (push) begin
      e.data = w ? last[s] : exp_rd;
      e.err  = exp_err;
      e.gcyc = gcyc;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
      push_cnt[s]++;
      if (!w) last[s] = exp_rd;
    end
    @(posedge clk);
    #1;
    if (!hold) req[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hard stop in case something upstream deadlocks.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w, g, g_prev;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];
    b2b_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    n_checks = 0; n_errors = 0;
    lat[0] = 1; lat[1] = 4;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; be[s] = '0;
      wdata[s] = '0; last[s] = '0; rv_cnt[s] = 0; push_cnt[s] = 0;
    end
    req[0] = 1'b1;   // grant must stay low while reset is held

    // Reset state.
    repeat (3) begin
      @(negedge clk);
      check("gnt_in_reset dut0", {31'b0, gnt[0]}, 32'h0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_rvalid dut%0d", s), {31'b0, rvalid[s]}, 32'h0);
      check($sformatf("reset_rdata dut%0d", s), rdata[s], 32'h0);
      check($sformatf("reset_error dut%0d", s), {31'b0, err[s]}, 32'h0);
    end

    // 1: write then read, grant in the request cycle.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1, w, g);
    check("gnt_wait_write dut0", 32'(w), 32'd0);
    idle(1);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1, w, g);
    check("gnt_wait_read dut0", 32'(w), 32'd0);

    // 2: partial byte enables, then an all-zero enable write.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 0, 1, w, g);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, 0, 1, w, g);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 0, 1, w, g);
    issue(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 1, w, g);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 0, 1, w, g);

    // 4: back-to-back reads with req held high.
    for (int i = 0; i < 4; i++)
      issue(0, 1'b1, b2b_addr[i], 4'hF, b2b_data[i], 32'h0, 1'b0, 0, 1, w, g);
    idle(1);
    g_prev = -1;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, b2b_addr[i], 4'h0, 32'h0, b2b_data[i], 1'b0, 1, 1, w, g);
      if (i > 0) check("b2b_gnt_spacing dut0", 32'(g - g_prev), 32'd2);
      g_prev = g;
    end
    req[0] = 1'b0;
    idle(2);

    // 6: address aliasing / range check.
    issue(0, 1'b1, 32'h4, 4'hF, 32'h01010101, 32'h0, 1'b0, 0, 1, w, g);
    issue(0, 1'b1, 32'h1004, 4'hF, 32'h5A5A5A5A, 32'h0, RC, 0, 1, w, g);
    issue(0, 1'b0, 32'h4, 4'h0, 32'h0, RC ? 32'h01010101 : 32'h5A5A5A5A, 1'b0, 0, 1, w, g);
    issue(0, 1'b0, 32'h1004, 4'h0, 32'h0, RC ? 32'h0 : 32'h5A5A5A5A, RC, 0, 1, w, g);

    // 3: long latencies on instance 1.
    issue(1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1, w, g);
    check("gnt_wait dut1", 32'(w), 32'd3);
    idle(6);
    issue(1, 1'b0, 32'h30, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1, w, g);
    check("gnt_wait_read dut1", 32'(w), 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("no_gnt_in_respond dut1", {31'b0, gnt[1]}, 32'h0);
    end
    req[1] = 1'b0;
    idle(3);

    // 5: reset one cycle after a read grant drops its response.
    issue(1, 1'b0, 32'h30, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0, w, g);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    last[1] = 32'h0;
    @(negedge clk);
    check("rdata_after_reset dut1", rdata[1], 32'h0);
    idle(8);
    // A write granted just before reset stays committed.
    issue(1, 1'b1, 32'h34, 4'hF, 32'h0BADC0DE, 32'h0, 1'b0, 0, 0, w, g);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    idle(8);
    issue(1, 1'b0, 32'h34, 4'h0, 32'h0, 32'h0BADC0DE, 1'b0, 0, 1, w, g);

    // Drain and account for every response.
    idle(10);
    check("drain_q dut0", 32'(q0.size()), 32'd0);
    check("drain_q dut1", 32'(q1.size()), 32'd0);
    check("rvalid_count dut0", 32'(rv_cnt[0]), 32'(push_cnt[0]));
    check("rvalid_count dut1", 32'(rv_cnt[1]), 32'(push_cnt[1]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
